// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   ifu_state_e : fetch FSM states
//   CLASS_*     : position and encodings of the instruction class field
package ifu_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StIssue,
      StHalt
   } ifu_state_e;

   localparam int unsigned CLASS_HI = 19;
   localparam int unsigned CLASS_LO = 18;

   localparam logic [1:0] CLASS_HALT  = 2'b00;
   localparam logic [1:0] CLASS_ALU   = 2'b01;
   localparam logic [1:0] CLASS_LOAD  = 2'b10;
   localparam logic [1:0] CLASS_STORE = 2'b11;

   function automatic logic is_halt_class(input logic [1:0] cls);
      return cls == CLASS_HALT;
   endfunction

endpackage

// File: rtl/instr_fetch_unit_mem.sv
// Program memory for the fetch unit: 2**AddrBits words of Width bits.
// Synchronous write; synchronous read into a register that drives the CPU
// instruction bus directly and is cleared by the asynchronous reset.
// Ports:
//   clk_i, rst_ni      clock, async active-low reset (read register only)
//   we_i/waddr_i/wdata_i  write port
//   re_i/raddr_i       read enable and address
//   rdata_o            registered read data
//   rclass_o           class field of mem[raddr_i], used to decide HALT at the
//                      same edge that loads rdata_o
module instr_mem
   import ifu_pkg::*;
#(
   parameter int unsigned Width    = 20,
   parameter int unsigned AddrBits = 5
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                we_i,
   input  logic [AddrBits-1:0] waddr_i,
   input  logic [Width-1:0]    wdata_i,
   input  logic                re_i,
   input  logic [AddrBits-1:0] raddr_i,
   output logic [Width-1:0]    rdata_o,
   output logic [1:0]          rclass_o
);

   localparam int unsigned Depth = 2 ** AddrBits;

   logic [Width-1:0] mem_q [Depth];
   logic [Width-1:0] rdata_q;

   // Array is deliberately left without reset: contents survive rst_ni.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o  = rdata_q;
   assign rclass_o = mem_q[raddr_i][CLASS_HI:CLASS_LO];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: steps a PC through a loadable program memory and
// presents one instruction at a time to the CPU over a valid/ready handshake.
// Stops on a HALT-class word or after issuing the last memory word.
// Optional feature macro: IFU_STATS_EN adds issue_count_o, a saturating
// count of handshakes cleared by reset and by an accepted start.
// Ports:
//   clk_i, rst_ni                    clock, async active-low reset
//   prog_we_i/prog_addr_i/prog_data_i program load (ignored while busy)
//   start_i                          run from pc=0 (ignored while busy)
//   cpu_ready_i                      CPU accepts the presented instruction
//   instruction_o, instr_valid_o     instruction to CPU
//   pc_o                             address of presented/next instruction
//   busy_o, halted_o                 status
//   issue_count_o                    only with IFU_STATS_EN
module instr_fetch_unit
   import ifu_pkg::*;
#(
   parameter int unsigned INSTR_WIDTH = 20,
   parameter int unsigned PC_BITS     = 5
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   prog_we_i,
   input  logic [PC_BITS-1:0]     prog_addr_i,
   input  logic [INSTR_WIDTH-1:0] prog_data_i,
   input  logic                   start_i,
   input  logic                   cpu_ready_i,
   output logic [INSTR_WIDTH-1:0] instruction_o,
   output logic                   instr_valid_o,
   output logic [PC_BITS-1:0]     pc_o,
   output logic                   busy_o,
   output logic                   halted_o
`ifdef IFU_STATS_EN
   ,
   output logic [7:0]             issue_count_o
`endif
);

   localparam logic [PC_BITS-1:0] PcLast = '1;
   localparam logic [PC_BITS-1:0] PcOne  = {{(PC_BITS-1){1'b0}}, 1'b1};

   ifu_state_e         state_q;
   logic [PC_BITS-1:0] pc_q;
   logic               valid_q;

   logic               busy;
   logic               accept_start;
   logic               handshake;
   logic               mem_re;
   logic [1:0]         mem_class;

   assign busy         = (state_q == StFetch) || (state_q == StIssue);
   assign accept_start = start_i && !busy;
   assign handshake    = (state_q == StIssue) && valid_q && cpu_ready_i;
   assign mem_re       = (state_q == StFetch);

   instr_mem #(
      .Width    (INSTR_WIDTH),
      .AddrBits (PC_BITS)
   ) u_mem (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .we_i     (prog_we_i && !busy),
      .waddr_i  (prog_addr_i),
      .wdata_i  (prog_data_i),
      .re_i     (mem_re),
      .raddr_i  (pc_q),
      .rdata_o  (instruction_o),
      .rclass_o (mem_class)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         pc_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle, StHalt: begin
               if (start_i) begin
                  state_q <= StFetch;
                  pc_q    <= '0;
               end
            end
            StFetch: begin
               // Class is decided from the array at the same edge that loads
               // the read register, so a HALT word is never presented as valid.
               if (is_halt_class(mem_class)) begin
                  state_q <= StHalt;
                  valid_q <= 1'b0;
               end else begin
                  state_q <= StIssue;
                  valid_q <= 1'b1;
               end
            end
            StIssue: begin
               if (handshake) begin
                  valid_q <= 1'b0;
                  if (pc_q == PcLast) begin
                     state_q <= StHalt;
                  end else begin
                     pc_q    <= pc_q + PcOne;
                     state_q <= StFetch;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign instr_valid_o = valid_q;
   assign pc_o          = pc_q;
   assign busy_o        = busy;
   assign halted_o      = (state_q == StHalt);

`ifdef IFU_STATS_EN
   logic [7:0] issue_count_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         issue_count_q <= '0;
      end else if (accept_start) begin
         issue_count_q <= '0;
      end else if (handshake && (issue_count_q != 8'hFF)) begin
         issue_count_q <= issue_count_q + 8'd1;
      end
   end

   assign issue_count_o = issue_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit. Expected (instruction, pc) pairs
// are derived from a bench-side memory model when a run starts and popped by
// a monitor at every handshake. IFU_STATS_EN enables the counter checks.
module tb_instr_fetch_unit;
   import ifu_pkg::*;

   typedef struct packed {
      logic [19:0] instr;
      logic [4:0]  pc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        prog_we;
   logic [4:0]  prog_addr;
   logic [19:0] prog_data;
   logic        start;
   logic        cpu_ready;
   logic [19:0] instruction;
   logic        instr_valid;
   logic [4:0]  pc;
   logic        busy;
   logic        halted;
`ifdef IFU_STATS_EN
   logic [7:0]  issue_count;
`endif

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          issues   = 0;
   logic        mon_en   = 1'b1;
   logic [19:0] mem_m [32];
   exp_t        exp_q [$];
   int          hs_cyc [$];

   instr_fetch_unit #(
      .INSTR_WIDTH (20),
      .PC_BITS     (5)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .prog_we_i     (prog_we),
      .prog_addr_i   (prog_addr),
      .prog_data_i   (prog_data),
      .start_i       (start),
      .cpu_ready_i   (cpu_ready),
      .instruction_o (instruction),
      .instr_valid_o (instr_valid),
      .pc_o          (pc),
      .busy_o        (busy),
      .halted_o      (halted)
`ifdef IFU_STATS_EN
      ,
      .issue_count_o (issue_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: a handshake happens at the next rising edge.
   always @(negedge clk) begin
      cyc++;
      if (mon_en && rst_n && instr_valid && cpu_ready) begin
         exp_t e;
         issues++;
         hs_cyc.push_back(cyc);
         check_eq("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("issue_instr", 32'(instruction), 32'(e.instr));
            check_eq("issue_pc", 32'(pc), 32'(e.pc));
         end
      end
   end

   task automatic load_raw(input logic [4:0] a, input logic [19:0] d);
      @(posedge clk); #1;
      prog_we = 1'b1; prog_addr = a; prog_data = d;
      @(posedge clk); #1;
      prog_we = 1'b0;
   endtask

   task automatic program_word(input logic [4:0] a, input logic [19:0] d);
      mem_m[a] = d;
      load_raw(a, d);
   endtask

   task automatic pulse_start();
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Walks the model the way a run should and queues the expected issues.
   task automatic start_run(output logic [4:0] halt_pc);
      logic [4:0] p = 5'd0;
      forever begin
         if (mem_m[p][19:18] == 2'b00) begin
            halt_pc = p;
            break;
         end
         exp_q.push_back('{instr: mem_m[p], pc: p});
         if (p == 5'd31) begin
            halt_pc = p;
            break;
         end
         p = p + 5'd1;
      end
      pulse_start();
   endtask

   task automatic pulse_ready();
      @(posedge clk); #1;
      cpu_ready = 1'b1;
      @(posedge clk); #1;
      cpu_ready = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!instr_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, 32'(instr_valid), 32'd1);
   endtask

   task automatic wait_halted(input string tag, input int bound, input logic [4:0] exp_pc);
      int n = 0;
      while (!halted && n < bound) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, "_halted"}, 32'(halted), 32'd1);
      check_eq({tag, "_pc"}, 32'(pc), 32'(exp_pc));
      check_eq({tag, "_valid"}, 32'(instr_valid), 32'd0);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      logic [4:0] hpc;
      rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      start = 1'b0; cpu_ready = 1'b0;
      for (int i = 0; i < 32; i++) mem_m[i] = '0;

      #12;
      check_eq("rst_valid", 32'(instr_valid), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_halted", 32'(halted), 32'd0);
      check_eq("rst_pc", 32'(pc), 32'd0);
      check_eq("rst_instr", 32'(instruction), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Program and run with the CPU always ready.
      program_word(5'd0, 20'h47000);
      program_word(5'd1, 20'h53000);
      program_word(5'd2, 20'h00000);
      cpu_ready = 1'b1;
      hs_cyc.delete();
      start_run(hpc);
      @(negedge clk);
      check_eq("fetch_busy", 32'(busy), 32'd1);
      check_eq("fetch_valid", 32'(instr_valid), 32'd0);
      @(negedge clk);
      check_eq("first_valid", 32'(instr_valid), 32'd1);
      wait_halted("run", 40, hpc);
      check_eq("run_hs_count", 32'(hs_cyc.size()), 32'd2);
      if (hs_cyc.size() == 2) check_eq("run_hs_gap", 32'(hs_cyc[1] - hs_cyc[0]), 32'd2);

      // Backpressure on the second word.
      cpu_ready = 1'b0;
      program_word(5'd1, 20'hDC0F0);
      start_run(hpc);
      wait_valid("bp_first_valid");
      pulse_ready();
      wait_valid("bp_second_valid");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("bp_instr", 32'(instruction), 32'h000DC0F0);
         check_eq("bp_pc", 32'(pc), 32'd1);
         check_eq("bp_valid", 32'(instr_valid), 32'd1);
      end
      issues = 0;
      cpu_ready = 1'b1;
      wait_halted("bp", 40, hpc);
      check_eq("bp_one_issue", 32'(issues), 32'd1);

      // Asynchronous reset in the middle of ISSUE, away from any edge.
      cpu_ready = 1'b0;
      start_run(hpc);
      wait_valid("rst2_first_valid");
      pulse_ready();
      wait_valid("rst2_second_valid");
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_eq("arst_valid", 32'(instr_valid), 32'd0);
      check_eq("arst_instr", 32'(instruction), 32'd0);
      check_eq("arst_pc", 32'(pc), 32'd0);
      check_eq("arst_busy", 32'(busy), 32'd0);
      check_eq("arst_halted", 32'(halted), 32'd0);
      check_eq("arst_state", 32'(dut.state_q), 32'(StIdle));
      exp_q.delete();
      #1 rst_n = 1'b1;

      // End of memory: no HALT word anywhere.
      for (int i = 0; i < 32; i++) program_word(5'(i), 20'h40000);
      cpu_ready = 1'b1;
      issues = 0;
      start_run(hpc);
      wait_halted("eom", 200, 5'd31);
      check_eq("eom_issues", 32'(issues), 32'd32);

      // start/prog_we while busy are ignored; restart from HALT re-issues mem[0].
      cpu_ready = 1'b0;
      program_word(5'd0, 20'h50001);
      program_word(5'd1, 20'h60002);
      program_word(5'd2, 20'h00000);
      start_run(hpc);
      wait_valid("ign_valid");
      load_raw(5'd1, 20'h7FFFF);
      pulse_start();
      @(negedge clk);
      check_eq("ign_pc", 32'(pc), 32'd0);
      check_eq("ign_instr", 32'(instruction), 32'h00050001);
      check_eq("ign_busy", 32'(busy), 32'd1);
      cpu_ready = 1'b1;
      wait_halted("ign", 40, hpc);
      start_run(hpc);
      wait_halted("restart", 40, hpc);

`ifdef IFU_STATS_EN
      program_word(5'd0, 20'h40000);
      program_word(5'd1, 20'h40000);
      program_word(5'd2, 20'h40000);
      program_word(5'd3, 20'h00000);
      start_run(hpc);
      wait_halted("st3", 40, hpc);
      check_eq("stats_3", 32'(issue_count), 32'd3);
      program_word(5'd3, 20'h40000);
      cpu_ready = 1'b0;
      start_run(hpc);
      wait_valid("st_sat_valid");
      // A single run issues at most 32 words, so preload the counter near the top.
      @(negedge clk);
      force dut.issue_count_q = 8'd250;
      @(negedge clk);
      release dut.issue_count_q;
      cpu_ready = 1'b1;
      wait_halted("stsat", 200, 5'd31);
      check_eq("stats_sat", 32'(issue_count), 32'd255);
      cpu_ready = 1'b0;
      start_run(hpc);
      @(negedge clk);
      check_eq("stats_clear", 32'(issue_count), 32'd0);
      cpu_ready = 1'b1;
      wait_halted("stclr", 200, 5'd31);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
